// File: rtl/aes_round_ctrl_pkg.sv
// aes_round_ctrl_pkg: shared FSM state, source-select encoding and round count for the AES decryption sequencer
package aes_pkg;
  localparam int AES_NUM_ROUNDS = 10;
  typedef enum logic [2:0] {IDLE, KEYEXP, ARK0, ISR, ISB, ARK, IMC, DONE} aes_ctrl_state_t;
  typedef enum logic [2:0] {SEL_MSG = 3'd0, SEL_ARK = 3'd1, SEL_ISR = 3'd2, SEL_ISB = 3'd3, SEL_IMC = 3'd4} aes_sel_t;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: START/DONE handshake plus datapath strobes and selects of the round sequencer
interface aes_round_ctrl_if;
  import aes_pkg::*;
  logic AES_START;
  logic AES_DONE;
  logic busy;
  logic key_ld;
  logic state_ld;
  aes_sel_t state_sel;
  logic [3:0] round_idx;
  logic [1:0] col_sel;
  logic out_ld;
  modport master (input AES_START, output AES_DONE, busy, key_ld, state_ld, state_sel, round_idx, col_sel, out_ld);
  modport slave (output AES_START, input AES_DONE, busy, key_ld, state_ld, state_sel, round_idx, col_sel, out_ld);
endinterface

// File: rtl/aes_round_ctrl_wait_cnt.sv
// aes_wait_cnt: loadable down-counter saturating at zero, with a zero flag
module aes_wait_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ld,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) cnt <= '0;
    else cnt <= ld ? val : zero ? cnt : cnt - W'(1);
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: Moore sequencer for the AES-128 decryption datapath (START/DONE handshake, round walk).
// Define AES_CTRL_ABORT_EN to let AES_START falling while busy abort the operation.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS    = AES_NUM_ROUNDS,
  parameter int KEYEXP_CYCLES = 10,
  parameter int SUBBYTES_LAT  = 2
) (
  input logic CLK,
  input logic RESET,
  aes_round_ctrl_if.master bus
);
  localparam int W = 8;
`ifdef AES_CTRL_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  aes_ctrl_state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] col_q, col_d;
  logic wld, wzero;
  logic [W-1:0] wval, wcnt;
  aes_wait_cnt #(.W(W)) u_wait (
    .CLK  (CLK),
    .RESET(RESET),
    .ld   (wld),
    .val  (wval),
    .cnt  (wcnt),
    .zero (wzero)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      col_q   <= col_d;
    end
  assign bus.busy      = state_q != IDLE && state_q != DONE;
  assign bus.AES_DONE  = state_q == DONE;
  assign bus.round_idx = rnd_q;
  assign bus.col_sel   = state_q == IMC ? col_q : 2'd0;
  assign bus.key_ld    = state_q == KEYEXP && wcnt == W'(KEYEXP_CYCLES - 1);
  always_comb begin
    state_d       = state_q;
    rnd_d         = rnd_q;
    col_d         = col_q;
    wld           = 1'b0;
    wval          = '0;
    bus.state_ld  = 1'b0;
    bus.state_sel = SEL_MSG;
    bus.out_ld    = 1'b0;
    case (state_q)
      IDLE: if (bus.AES_START) begin
        state_d = KEYEXP;
        rnd_d   = 4'(NUM_ROUNDS);
        wld     = 1'b1;
        wval    = W'(KEYEXP_CYCLES - 1);
      end
      KEYEXP: if (wzero) begin
        bus.state_ld = 1'b1;
        state_d      = ARK0;
      end
      ARK0: begin
        bus.state_ld  = 1'b1;
        bus.state_sel = SEL_ARK;
        rnd_d         = rnd_q - 4'd1;
        state_d       = ISR;
      end
      ISR: begin
        bus.state_ld  = 1'b1;
        bus.state_sel = SEL_ISR;
        wld           = 1'b1;
        wval          = W'(SUBBYTES_LAT - 1);
        state_d       = ISB;
      end
      ISB: if (wzero) begin
        bus.state_ld  = 1'b1;
        bus.state_sel = SEL_ISB;
        state_d       = ARK;
      end
      ARK: begin
        bus.state_ld  = 1'b1;
        bus.state_sel = SEL_ARK;
        bus.out_ld    = rnd_q == 4'd0;
        state_d       = rnd_q == 4'd0 ? DONE : IMC;
        col_d         = 2'd0;
      end
      IMC: begin
        bus.state_ld  = 1'b1;
        bus.state_sel = SEL_IMC;
        col_d         = col_q + 2'd1;
        rnd_d         = col_q == 2'd3 ? rnd_q - 4'd1 : rnd_q;
        state_d       = col_q == 2'd3 ? ISR : IMC;
      end
      DONE: if (!bus.AES_START) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // an abort must never let a partial result reach the output register
    if (ABORT_EN && bus.busy && !bus.AES_START) begin
      state_d    = IDLE;
      bus.out_ld = 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed checks of the AES decryption round sequencer handshake and strobe sequence
module tb_aes_round_ctrl;
  import aes_pkg::*;
  logic CLK = 1'b0;
  logic RESET;
  int nchk = 0, nerr = 0;
  int ark_q[$];
  int imc_n = 0, col_bad = 0, out_n = 0, key_n = 0, isb2_n = 0;
  logic [1:0] exp_col = 2'd0;
  aes_round_ctrl_if bus1 ();
  aes_round_ctrl_if bus2 ();
  aes_round_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus1));
  aes_round_ctrl #(.KEYEXP_CYCLES(1), .SUBBYTES_LAT(1)) dut2 (.CLK(CLK), .RESET(RESET), .bus(bus2));
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (!RESET) begin
    if (bus1.state_ld && bus1.state_sel == SEL_ARK) begin
      ark_q.push_back(int'(bus1.round_idx));
      exp_col = 2'd0;
    end
    if (bus1.state_ld && bus1.state_sel == SEL_IMC) begin
      if (bus1.col_sel != exp_col) col_bad++;
      exp_col = exp_col + 2'd1;
      imc_n++;
    end
    if (bus1.out_ld) out_n++;
    if (bus1.key_ld) key_n++;
    if (bus2.state_ld && bus2.state_sel == SEL_ISB) isb2_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_op(input int drop_at, output int edges, output bit prev_out);
    edges = 0;
    prev_out = 1'b0;
    bus1.AES_START = 1'b1;
    @(posedge CLK);
    for (int n = 1; n <= 200; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus1.AES_DONE) begin
        edges = n;
        break;
      end
      prev_out = bus1.out_ld;
      if (n == drop_at) bus1.AES_START = 1'b0;
    end
  endtask
  initial begin
    int e, a0, i0, o0, k0, c0, s0;
    bit po;
    RESET = 1'b1;
    bus1.AES_START = 1'b0;
    bus2.AES_START = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", bus1.busy, 0);
    check("rst_done", bus1.AES_DONE, 0);
    check("rst_state_ld", bus1.state_ld, 0);
    check("rst_round_idx", bus1.round_idx, 0);
    check("rst_key_ld", bus1.key_ld, 0);
    RESET = 1'b0;
    @(negedge CLK);
    a0 = ark_q.size(); i0 = imc_n; o0 = out_n; k0 = key_n; c0 = col_bad;
    run_op(0, e, po);
    check("done_edge", e, 87);
    check("out_ld_before_done", po, 1);
    check("ark_count", ark_q.size() - a0, 11);
    for (int i = 0; i <= 10; i++) check("ark_round_idx", (a0 + i < ark_q.size()) ? ark_q[a0 + i] : -1, 10 - i);
    check("imc_count", imc_n - i0, 36);
    check("imc_col_order", col_bad - c0, 0);
    check("out_ld_count", out_n - o0, 1);
    check("key_ld_count", key_n - k0, 1);
    repeat (5) @(negedge CLK);
    check("done_held", bus1.AES_DONE, 1);
    bus1.AES_START = 1'b0;
    @(negedge CLK);
    check("done_dropped", bus1.AES_DONE, 0);
    check("idle_busy", bus1.busy, 0);
    o0 = out_n;
    bus1.AES_START = 1'b1;
    @(negedge CLK);
    check("rekey_key_ld", bus1.key_ld, 1);
    @(negedge CLK);
    check("rekey_key_ld_once", bus1.key_ld, 0);
    repeat (38) @(negedge CLK);
    check("busy_at_40", bus1.busy, 1);
    RESET = 1'b1;
    #1;
    check("async_rst_busy", bus1.busy, 0);
    check("async_rst_state_ld", bus1.state_ld, 0);
    check("async_rst_round_idx", bus1.round_idx, 0);
    check("async_rst_done", bus1.AES_DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    bus1.AES_START = 1'b0;
    @(negedge CLK);
    check("rst_no_out_ld", out_n - o0, 0);
    check("rst_idle", bus1.busy, 0);
    run_op(0, e, po);
    check("after_rst_done_edge", e, 87);
    bus1.AES_START = 1'b0;
    @(negedge CLK);
    check("after_rst_idle", bus1.AES_DONE, 0);
    o0 = out_n;
    run_op(20, e, po);
`ifdef AES_CTRL_ABORT_EN
    check("abort_never_done", e, 0);
    check("abort_idle", bus1.busy, 0);
    check("abort_no_out_ld", out_n - o0, 0);
`else
    check("drop_done_edge", e, 87);
    check("drop_out_ld", out_n - o0, 1);
    @(negedge CLK);
    check("drop_done_one_cycle", bus1.AES_DONE, 0);
`endif
    s0 = isb2_n;
    e = 0;
    bus2.AES_START = 1'b1;
    @(posedge CLK);
    for (int n = 1; n <= 200; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus2.AES_DONE) begin
        e = n;
        break;
      end
    end
    check("fast_done_edge", e, 68);
    check("fast_isb_count", isb2_n - s0, 10);
    bus2.AES_START = 1'b0;
    @(negedge CLK);
    check("fast_idle", bus2.AES_DONE, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Moore-style sequencer driving the AES-128 decryption datapath (state register, AddRoundKey, InvShiftRows, InvSubBytes, per-column InvMixColumns, output register). It owns the START/DONE handshake with the Avalon register interface. It walks the round counter from NUM_ROUNDS down to 0. Each cycle it issues one load strobe plus mux selects. It holds no 128-bit data; all data stays in the datapath.

## Interface
- NUM_ROUNDS, 10: number of decryption rounds; round_idx starts here.
- KEYEXP_CYCLES, 10: cycles allowed for the key-schedule pipeline to settle (≥1).
- SUBBYTES_LAT, 2: cycles spent in InvSubBytes for the synchronous ROM (≥1).
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high.
- AES_START  in  1  level request from the register interface.
- AES_DONE  out  1  result valid; high only in DONE.
- busy  out  1  high in every state except IDLE and DONE.
- key_ld  out  1  one-cycle pulse to capture AES_KEY and start expansion.
- state_ld  out  1  load the datapath state register from the selected source.
- state_sel  out  3  source select: MSG, ARK, ISR, ISB, IMC.
- round_idx  out  4  key-schedule word index for AddRoundKey.
- col_sel  out  2  InvMixColumns column (0 = bits 127:96 … 3 = bits 31:0).
- out_ld  out  1  capture the state into AES_MSG_DEC.

## Operation
- States: IDLE, KEYEXP, ARK0, ISR, ISB, ARK, IMC, DONE.
- IDLE:
  - AES_START sampled high: go to KEYEXP, load round counter with NUM_ROUNDS, load wait counter with KEYEXP_CYCLES-1.
- KEYEXP:
  - key_ld=1 on the first cycle only.
  - On the last cycle (wait counter = 0): state_ld=1, state_sel=MSG; then go to ARK0.
- ARK0:
  - state_ld=1, state_sel=ARK, round_idx=NUM_ROUNDS.
  - Then go to ISR; the round counter decrements on this transition.
- ISR: state_ld=1, state_sel=ISR; go to ISB with wait counter = SUBBYTES_LAT-1.
- ISB: hold until wait counter = 0, then state_ld=1, state_sel=ISB; go to ARK.
- ARK:
  - state_ld=1, state_sel=ARK, round_idx=counter.
  - Counter = 0: out_ld=1, go to DONE.
  - Counter ≠ 0: go to IMC with col 0.
- IMC:
  - Four cycles, col_sel 0,1,2,3; state_ld=1, state_sel=IMC each cycle.
  - After col 3: counter decrements and the state goes to ISR.
- DONE:
  - AES_DONE=1.
  - Stay while AES_START=1; go to IDLE on the first cycle AES_START=0.
- round_idx always shows the counter value. The counter is 4 bits and never wraps below 0, because ARK with counter 0 always exits.
- AES_START changes during busy states are ignored (see Configuration).
- AES_START already low on arrival in DONE: DONE lasts exactly one cycle.

## Timing
- Reset values: state IDLE; all outputs and counters 0.
- RESET mid-operation forces IDLE asynchronously. Outputs drop immediately and AES_MSG_DEC is not loaded.
- Let edge 0 be the edge that samples AES_START=1 in IDLE. DONE is entered at edge KEYEXP_CYCLES + 1 + (NUM_ROUNDS-1)·(6+SUBBYTES_LAT) + (2+SUBBYTES_LAT). With default parameters this is edge 87.
- out_ld is asserted the cycle before AES_DONE rises, so AES_MSG_DEC is valid when AES_DONE is first seen high.
- AES_START held high in DONE keeps AES_DONE high indefinitely. A new operation needs AES_START low for at least one cycle, then high again.
- Exactly one state_ld per datapath step; state_ld is never asserted in IDLE or DONE.

## Configuration
- AES_CTRL_ABORT_EN defined:
  - AES_START=0 sampled in any busy state moves to IDLE on that edge.
  - No out_ld is issued and AES_DONE never rises.
- Not defined: AES_START is ignored while busy; the operation always completes.

## Structure
- Package aes_pkg holds:
  - the FSM state enum (aes_ctrl_state_t);
  - the source-select enum aes_sel_t: MSG=0, ARK=1, ISR=2, ISB=3, IMC=4;
  - constant AES_NUM_ROUNDS=10.
- Sub-module aes_wait_cnt: loadable down-counter with a zero flag, reused for the KEYEXP and ISB waits.

## Test plan
- Default parameters, single START pulse held until AES_DONE → AES_DONE rises after edge 87. Checks:
  - round_idx sequence on ARK strobes is 10,9,…,0.
  - Exactly 36 IMC strobes, col_sel cycling 0–3 nine times.
  - Exactly one out_ld.
- START held high after DONE → AES_DONE stays high. Drop START → IDLE next edge. Re-raise START → key_ld pulses again.
- RESET asserted at cycle 40 → outputs 0 immediately, state IDLE, no out_ld. A subsequent START completes in 87 cycles.
- START dropped at cycle 20:
  - AES_CTRL_ABORT_EN defined → IDLE at that edge, AES_DONE never rises.
  - Not defined → DONE at edge 87, AES_DONE high exactly one cycle.
- SUBBYTES_LAT=1, KEYEXP_CYCLES=1 → DONE at edge 1+1+63+3=68; ISB lasts one cycle per round.
- FIPS-197 vector: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, run with the reference datapath → AES_MSG_DEC = 00112233445566778899aabbccddeeff when AES_DONE=1.
